elevator_keypad_scanner: RTL and testbench
==========================================

Name: elevator_keypad_scanner

Overview:
Input-side counterpart of the elevator's multiplexed 7-segment display driver. It drives a 4x4 active-low button matrix one row at a time and reads the column returns. It debounces a single key at a time and emits a key event pulse with a 4-bit code. It also keeps latched floor-request and stop state for the elevator controller. It sits between the board's button matrix pins and the elevator FSM.

Parameters:
SCAN_DIV_W, 18, prescaler width; one scan tick every 2^SCAN_DIV_W clk cycles.
DEBOUNCE_SCANS, 3, consecutive matching samples of the candidate row needed to accept a press or a release (range 1..15).
REPEAT_SWEEPS, 8, full sweeps between auto-repeat events (used only with the optional feature).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
col_n  input  4  matrix column returns, active-low, asynchronous to clk
floor_clear  input  4  one-cycle pulses from controller; bit i clears floor_req[i]
row_n  output  4  matrix row drive, active-low one-cold
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  {row[1:0], col[1:0]} of the accepted key; holds until the next event
key_held  output  1  high while the accepted key remains pressed
floor_req  output  4  latched floor requests, bit i = floor i+1
stop_latch  output  1  emergency stop state, toggled by the stop key

Behaviour:
- Interface: single clock clk. rst is synchronous and active-high.
- Reset values:
  - row_n = 4'b1110
  - key_valid = 0, key_code = 0, key_held = 0
  - floor_req = 0, stop_latch = 0
  - prescaler = 0, FSM = IDLE, debounce counter = 0
  - both synchronizer stages = 4'b1111
- Reset mid-operation discards any pending press. No event is emitted.
- col_n passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Prescaler counts freely. tick = prescaler all-ones.
- On each tick, in the same cycle:
  - sample the synchronized columns for the row currently driven;
  - rotate row_n left (1110 → 1101 → 1011 → 0111 → 1110).
- One sweep = 4 ticks.
- The FSM evaluates samples only on ticks.
- IDLE:
  - Any low column in the sampled row sets candidate = {row, lowest low column index} and count = 1. Go to DEBOUNCE.
  - Earlier rows in the sweep win over later rows.
- DEBOUNCE, only on ticks sampling the candidate row:
  - Candidate column low: count += 1.
  - Candidate column high: go to IDLE with no event.
  - When count reaches DEBOUNCE_SCANS: pulse key_valid for 1 cycle, load key_code, set key_held, count = 0, go to HELD.
  - With DEBOUNCE_SCANS = 1, the event fires on the detecting tick + 1 cycle.
- HELD, only on candidate-row samples:
  - Column high: count += 1.
  - Column low: count = 0.
  - When count reaches DEBOUNCE_SCANS: clear key_held, go to IDLE.
- Other keys pressed while not in IDLE are ignored.
- Key actions, applied in the cycle key_valid is high:
  - codes 0–3 (cabin) and 4–7 (hall) set floor_req[code[1:0]];
  - code 10 toggles stop_latch;
  - all other codes produce the event only.
- floor_clear[i] clears floor_req[i]. If set and clear hit the same bit in the same cycle, set wins.
- Latency from a stable press to key_valid: the detecting tick + (DEBOUNCE_SCANS−1) sweeps + 1 clk.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in HELD, while the key stays pressed, key_valid re-pulses every REPEAT_SWEEPS sweeps with the same key_code. Repeats of code 10 do not toggle stop_latch.
- Undefined: exactly one event per press. REPEAT_SWEEPS is unused and no repeat counter is synthesized.

Decomposition:
- elevator_pkg holds:
  - FSM state enum: IDLE, DEBOUNCE, HELD;
  - key code constants KEY_CAB_F1..F4 = 0..3, KEY_HALL_F1..F4 = 4..7, KEY_DOOR_OPEN = 8, KEY_DOOR_CLOSE = 9, KEY_STOP = 10;
  - ROW_INIT = 4'b1110.
- One sub-module: keypad_scan_tick, containing the prescaler, the tick output and the row rotation.

Test Plan:
1. SCAN_DIV_W=4, DEBOUNCE_SCANS=3. Hold col_n=4'b1101 while row_n=1110 → key_valid pulses once with key_code=1 and floor_req=4'b0010, 2 sweeps (128 clk) after detection, ±sync latency.
2. Glitch col_n[0] low for 1 tick on row 0 → no key_valid, FSM back in IDLE, floor_req unchanged.
3. Press key 10, release, press again → stop_latch goes 0 → 1 → 0. key_held falls DEBOUNCE_SCANS row-0/row-2 samples after each release.
4. floor_req=4'b0100, then floor_clear=4'b0100 in the same cycle that key 2 is accepted → floor_req stays 4'b0100. A floor_clear pulse alone → 4'b0000.
5. Keys 1 and 6 held together from IDLE → only key_code=1 is reported. Key 6 is never reported while key 1 is held.
6. Assert rst during DEBOUNCE → next cycle row_n=1110, all outputs zero, and no key_valid for the aborted press.

Source files
------------

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the elevator keypad scanner.
//   kp_state_t   : scanner FSM states (IDLE / DEBOUNCE / HELD)
//   KEY_*        : 4-bit key codes, laid out as {row[1:0], col[1:0]}
//   ROW_INIT     : row drive pattern after reset (row 0 driven low)
//   lowest_low() : index of the lowest active-low column in a sample
// ---------------------------------------------------------------------------
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  localparam logic [3:0] KEY_CAB_F1     = 4'd0;
  localparam logic [3:0] KEY_CAB_F2     = 4'd1;
  localparam logic [3:0] KEY_CAB_F3     = 4'd2;
  localparam logic [3:0] KEY_CAB_F4     = 4'd3;
  localparam logic [3:0] KEY_HALL_F1    = 4'd4;
  localparam logic [3:0] KEY_HALL_F2    = 4'd5;
  localparam logic [3:0] KEY_HALL_F3    = 4'd6;
  localparam logic [3:0] KEY_HALL_F4    = 4'd7;
  localparam logic [3:0] KEY_DOOR_OPEN  = 4'd8;
  localparam logic [3:0] KEY_DOOR_CLOSE = 4'd9;
  localparam logic [3:0] KEY_STOP       = 4'd10;

  localparam logic [3:0] ROW_INIT = 4'b1110;

  // Lowest-numbered column that reads low; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] cols_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// ---------------------------------------------------------------------------
// keypad_scan_tick
// Free-running prescaler producing one scan tick every 2^SCAN_DIV_W cycles,
// and the one-cold row drive that advances on every tick.
//   i_clk, i_rst : clock, synchronous active-high reset
//   o_tick       : high for one cycle when the prescaler is all-ones
//   o_row_idx    : index of the row currently driven (sampled on the tick)
//   o_row_n      : active-low one-cold row drive
// ---------------------------------------------------------------------------
module keypad_scan_tick
  import elevator_pkg::*;
#(
  parameter int SCAN_DIV_W = 18
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_tick,
  output logic [1:0] o_row_idx,
  output logic [3:0] o_row_n
);

  logic [SCAN_DIV_W-1:0] r_presc;
  logic [1:0]            r_row_idx;
  logic [3:0]            r_row_n;
  logic                  w_tick;

  assign w_tick = &r_presc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_row_idx <= 2'd0;
      r_row_n   <= ROW_INIT;
    end else begin
      r_presc <= r_presc + 1'b1;
      // The tick samples the row driven now; the rotation takes effect after.
      if (w_tick) begin
        r_row_idx <= r_row_idx + 2'd1;
        r_row_n   <= {r_row_n[2:0], r_row_n[3]};
      end
    end
  end

  assign o_tick    = w_tick;
  assign o_row_idx = r_row_idx;
  assign o_row_n   = r_row_n;

endmodule

// File: rtl/elevator_keypad_scanner.sv
// ---------------------------------------------------------------------------
// elevator_keypad_scanner
// Scans a 4x4 active-low button matrix, debounces one key at a time, emits a
// key event with its code and keeps latched floor-request / stop state.
//   clk, rst     : clock, synchronous active-high reset
//   col_n        : column returns (active-low, asynchronous)
//   floor_clear  : per-floor clear pulses from the elevator controller
//   row_n        : one-cold active-low row drive
//   key_valid    : one-cycle pulse per accepted key event
//   key_code     : {row, col} of the last event
//   key_held     : accepted key still pressed
//   floor_req    : latched floor requests
//   stop_latch   : emergency stop state
// Optional build macro KEYPAD_AUTOREPEAT_EN: re-pulse key_valid every
// REPEAT_SWEEPS sweeps while the accepted key stays pressed.
// ---------------------------------------------------------------------------
module elevator_keypad_scanner
  import elevator_pkg::*;
#(
  parameter int SCAN_DIV_W     = 18,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SWEEPS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  input  logic [3:0] floor_clear,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] floor_req,
  output logic       stop_latch
);

  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [3:0] r_sync1, r_sync2;
  logic       w_tick;
  logic [1:0] w_row_idx;
  logic [3:0] w_row_n;

  kp_state_t  r_state, w_state_nx;
  logic [3:0] r_cand, r_count, r_key_code, r_floor_req;
  logic       r_key_valid, r_key_held, r_stop;

  logic       w_any_low, w_cand_row, w_cand_low, w_count_hit;
  logic [1:0] w_low_idx;
  logic [3:0] w_count_inc, w_fire_code, w_floor_set;
  logic       w_fire, w_release, w_rep, w_is_rep, w_stop_toggle;

  keypad_scan_tick #(.SCAN_DIV_W(SCAN_DIV_W)) u_tick (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_tick   (w_tick),
    .o_row_idx(w_row_idx),
    .o_row_n  (w_row_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= col_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_any_low   = ~&r_sync2;
  assign w_low_idx   = lowest_low(r_sync2);
  // Only ticks that sample the candidate's row advance DEBOUNCE / HELD.
  assign w_cand_row  = w_tick && (w_row_idx == r_cand[3:2]);
  assign w_cand_low  = ~r_sync2[r_cand[1:0]];
  assign w_count_inc = r_count + 4'd1;
  assign w_count_hit = (w_count_inc == DS);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:     if (w_tick && w_any_low) w_state_nx = (DS == 4'd1) ? HELD : DEBOUNCE;
      DEBOUNCE: if (w_cand_row) begin
                  if (!w_cand_low)      w_state_nx = IDLE;
                  else if (w_count_hit) w_state_nx = HELD;
                end
      HELD:     if (w_release) w_state_nx = IDLE;
      default:  w_state_nx = IDLE;
    endcase
  end

  // FSM outputs: accept / release strobes
  always_comb begin
    w_fire      = 1'b0;
    w_release   = 1'b0;
    w_fire_code = r_cand;
    case (r_state)
      IDLE: if (w_tick && w_any_low && DS == 4'd1) begin
              w_fire      = 1'b1;
              w_fire_code = {w_row_idx, w_low_idx};
            end
      DEBOUNCE: w_fire    = w_cand_row && w_cand_low && w_count_hit;
      HELD:     w_release = w_cand_row && !w_cand_low && w_count_hit;
      default: ;
    endcase
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SWEEPS + 1);
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_is_rep;
  logic             w_held_low;

  assign w_held_low = (r_state == HELD) && w_cand_row && w_cand_low;
  assign w_rep      = w_held_low && ((r_rep_cnt + 1'b1) == REP_W'(REPEAT_SWEEPS));
  assign w_is_rep   = r_is_rep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt <= '0;
      r_is_rep  <= 1'b0;
    end else begin
      r_is_rep <= w_rep;
      if (w_fire)          r_rep_cnt <= '0;
      else if (w_held_low) r_rep_cnt <= w_rep ? '0 : r_rep_cnt + 1'b1;
    end
  end
`else
  // Repeat disabled: the comparison folds to a constant zero.
  assign w_rep    = (REPEAT_SWEEPS < 0);
  assign w_is_rep = 1'b0;
`endif

  // Actions act on the registered event, i.e. the cycle key_valid is high.
  assign w_floor_set   = (r_key_valid && !r_key_code[3]) ? (4'b0001 << r_key_code[1:0]) : 4'b0000;
  assign w_stop_toggle = r_key_valid && (r_key_code == KEY_STOP) && !w_is_rep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand      <= 4'd0;
      r_count     <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_key_held  <= 1'b0;
      r_floor_req <= 4'd0;
      r_stop      <= 1'b0;
    end else begin
      r_key_valid <= w_fire | w_rep;
      if (w_fire) begin
        r_key_code <= w_fire_code;
        r_key_held <= 1'b1;
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_tick && w_any_low) begin
                r_cand  <= {w_row_idx, w_low_idx};
                r_count <= (DS == 4'd1) ? 4'd0 : 4'd1;
              end
        DEBOUNCE: if (w_cand_row) r_count <= (!w_cand_low || w_count_hit) ? 4'd0 : w_count_inc;
        HELD:     if (w_cand_row) r_count <= (w_cand_low || w_count_hit) ? 4'd0 : w_count_inc;
        default:  r_count <= 4'd0;
      endcase
      // Set has priority over a coincident clear.
      r_floor_req <= (r_floor_req & ~floor_clear) | w_floor_set;
      if (w_stop_toggle) r_stop <= ~r_stop;
    end
  end

  assign row_n      = w_row_n;
  assign key_valid  = r_key_valid;
  assign key_code   = r_key_code;
  assign key_held   = r_key_held;
  assign floor_req  = r_floor_req;
  assign stop_latch = r_stop;

endmodule

// File: tb/tb_elevator_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_elevator_keypad_scanner
// Bench for elevator_keypad_scanner with SCAN_DIV_W=4 (tick every 16 clk,
// sweep of 64 clk) and DEBOUNCE_SCANS=3. A matrix model turns the set of
// pressed keys and the driven row into column returns. Expected event times
// are computed from the scan schedule: after reset the n-th clock edge is a
// tick when n is a multiple of 16, and it samples row (n/16 - 1) mod 4
// through a two-flop synchronizer.
// ---------------------------------------------------------------------------
module tb_elevator_keypad_scanner;

  localparam int SDW   = 4;
  localparam int DSC   = 3;
  localparam int SWEEP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] floor_clear = 4'd0;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] floor_req;
  logic       stop_latch;

  elevator_keypad_scanner #(
    .SCAN_DIV_W(SDW), .DEBOUNCE_SCANS(DSC), .REPEAT_SWEEPS(8)
  ) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .floor_clear(floor_clear),
    .row_n(row_n), .key_valid(key_valid), .key_code(key_code),
    .key_held(key_held), .floor_req(floor_req), .stop_latch(stop_latch)
  );

  always #5 clk = ~clk;

  logic [15:0] pressed = 16'd0;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && row_n[r] == 1'b0) col_n[c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int kv_cnt = 0;
  int kv_cyc = -1;
  logic [3:0] kv_code = 4'd0;
  logic [3:0] m_floor = 4'd0;
  logic       m_stop  = 1'b0;

  task automatic step();
    @(posedge clk);
    if (rst) cyc = 0; else cyc++;
    #1;
    if (key_valid === 1'b1) begin
      kv_cnt++;
      kv_cyc  = cyc;
      kv_code = key_code;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First tick edge that samples row r with a column change made after edge p.
  function automatic int sample_edge(input int p, input int r);
    for (int e = p + 3; e < p + 400; e++)
      if (e % 16 == 0 && ((e / 16 - 1) % 4) == r) return e;
    return -1;
  endfunction

  task automatic align_row0();
    for (int i = 0; i < SWEEP && (cyc % SWEEP) != 0; i++) step();
  endtask

  task automatic press(input int k, input logic [3:0] clr);
    int start, d;
    start = kv_cnt;
    pressed[k] = 1'b1;
    d = sample_edge(cyc, k / 4) + 2 * SWEEP;
    for (int i = 0; i < 400 && kv_cnt == start; i++) step();
    check("event_seen", kv_cnt - start, 1);
    check("event_cycle", kv_cyc, d);
    check("event_code", kv_code, k);
    floor_clear = clr;
    step();
    floor_clear = 4'd0;
    m_floor = m_floor & ~clr;
    if (k < 8) m_floor[k % 4] = 1'b1;
    if (k == 10) m_stop = ~m_stop;
    check("event_pulse", key_valid, 0);
    check("held_set", key_held, 1);
    check("floor_req", floor_req, m_floor);
    check("stop_latch", stop_latch, m_stop);
  endtask

  task automatic release_all();
    int e;
    logic [3:0] code;
    code = kv_code;
    e = sample_edge(cyc, code / 4) + 2 * SWEEP;
    pressed = 16'd0;
    for (int i = 0; i < 400 && key_held !== 1'b0; i++) step();
    check("held_fall", cyc, e);
    check("code_holds", key_code, code);
    for (int i = 0; i < 32; i++) step();
  endtask

  task automatic clear_pulse(input logic [3:0] m);
    floor_clear = m;
    step();
    floor_clear = 4'd0;
    m_floor = m_floor & ~m;
    check("floor_clear", floor_req, m_floor);
  endtask

  initial begin
    int start, d, k;
    logic [3:0] fr;

    // Reset state
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_held", key_held, 0);
    check("rst_floor_req", floor_req, 0);
    check("rst_stop", stop_latch, 0);
    rst = 1'b0;
    for (int i = 0; i < 20 && cyc < 16; i++) step();
    check("row_rotate", row_n, 4'b1101);

    // Cabin key 1 from row 0
    align_row0();
    press(1, 4'd0);
    release_all();
    clear_pulse(4'b0010);

    // One-sample glitch on column 0 of row 0
    align_row0();
    start = kv_cnt;
    fr = floor_req;
    pressed[0] = 1'b1;
    for (int i = 0; i < 16; i++) step();
    pressed[0] = 1'b0;
    for (int i = 0; i < 5 * SWEEP; i++) step();
    check("glitch_no_event", kv_cnt - start, 0);
    check("glitch_floor", floor_req, fr);

    // Stop key toggles on each press
    press(10, 4'd0);
    release_all();
    press(10, 4'd0);
    release_all();

    // Set wins over a coincident clear
    press(2, 4'd0);
    release_all();
    press(2, 4'b0100);
    release_all();
    clear_pulse(4'b0100);

    // Two keys together: the earlier row wins, the other is never reported
    align_row0();
    pressed[6] = 1'b1;
    start = kv_cnt;
    press(1, 4'd0);
    for (int i = 0; i < 5 * SWEEP; i++) step();
    check("multi_single_event", kv_cnt - start, 1);
    check("multi_code", key_code, 1);
    release_all();
    clear_pulse(4'b0010);

    // Reset during debounce
    start = kv_cnt;
    pressed[5] = 1'b1;
    d = sample_edge(cyc, 1) + 20;
    for (int i = 0; i < 400 && cyc < d; i++) step();
    rst = 1'b1;
    step();
    pressed = 16'd0;
    m_floor = 4'd0;
    m_stop  = 1'b0;
    check("abort_row_n", row_n, 4'b1110);
    check("abort_key_valid", key_valid, 0);
    check("abort_key_held", key_held, 0);
    check("abort_key_code", key_code, 0);
    check("abort_floor", floor_req, 0);
    check("abort_stop", stop_latch, 0);
    rst = 1'b0;
    for (int i = 0; i < 6 * SWEEP; i++) step();
    check("abort_no_event", kv_cnt - start, 0);

    // Randomized single-key presses against the event-level model
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < int'($urandom_range(0, 80)); i++) step();
      k = int'($urandom_range(0, 15));
      press(k, 4'd0);
      release_all();
      if ($urandom_range(0, 1) == 1) clear_pulse(4'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
